// File: rtl/id_ex_stage_pkg.sv
// Shared types and constants for the ID/EX stage: ALU control codes, ALUOp codes,
// R-type opcodes and the registered control/data bundles.
package id_ex_stage_pkg;

    localparam int N  = 64;
    localparam int RW = 5;
    localparam logic [RW-1:0] ZR = 5'd31;

    typedef enum logic [3:0] {
        ALU_AND   = 4'b0000,
        ALU_ORR   = 4'b0001,
        ALU_ADD   = 4'b0010,
        ALU_SUB   = 4'b0110,
        ALU_PASSB = 4'b0111,
        ALU_NOR   = 4'b1100
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_PASSB = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_ILL   = 2'b11
    } alu_op_e;

    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;

    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic illegal;
    } ex_ctrl_t;

    typedef struct packed {
        logic [N-1:0]  rd1;
        logic [N-1:0]  rd2;
        logic [N-1:0]  imm;
        logic [RW-1:0] rn;
        logic [RW-1:0] rm;
        logic [RW-1:0] rd;
        logic          alu_src;
        logic [3:0]    ctrl;
    } ex_data_t;

    // A writeback candidate feeds a source only for a live write to a real register.
    function automatic logic src_hit(input logic we, input logic [RW-1:0] wr, input logic [RW-1:0] src);
        return we && (wr == src) && (src != ZR);
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side and forwarding bus of the ID/EX stage; slave is the stage itself.
interface id_ex_stage_if;
    import id_ex_stage_pkg::*;

    logic          in_valid;
    logic [N-1:0]  in_rd1;
    logic [N-1:0]  in_rd2;
    logic [N-1:0]  in_imm;
    logic [RW-1:0] in_rn;
    logic [RW-1:0] in_rm;
    logic [RW-1:0] in_rd;
    logic          in_alu_src;
    logic [1:0]    in_alu_op;
    logic [10:0]   in_opcode;
    logic          in_reg_write;
    logic          in_mem_read;
    logic          in_mem_write;
    logic          in_branch;
    logic          stall_in;
    logic          flush;
    logic          exm_reg_write;
    logic [RW-1:0] exm_rd;
    logic [N-1:0]  exm_result;
    logic          mwb_reg_write;
    logic [RW-1:0] mwb_rd;
    logic [N-1:0]  mwb_result;

    logic          hazard_stall;
    logic          ex_valid;
    logic          ex_reg_write;
    logic          ex_mem_read;
    logic          ex_mem_write;
    logic          ex_branch;
    logic [RW-1:0] ex_rd;
    logic [N-1:0]  alu_a;
    logic [N-1:0]  alu_b;
    logic [3:0]    alu_ctrl;
    logic [N-1:0]  store_data;
    logic          illegal;

    modport master (
        output in_valid, in_rd1, in_rd2, in_imm, in_rn, in_rm, in_rd, in_alu_src, in_alu_op,
               in_opcode, in_reg_write, in_mem_read, in_mem_write, in_branch, stall_in, flush,
               exm_reg_write, exm_rd, exm_result, mwb_reg_write, mwb_rd, mwb_result,
        input  hazard_stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch,
               ex_rd, alu_a, alu_b, alu_ctrl, store_data, illegal
    );

    modport slave (
        input  in_valid, in_rd1, in_rd2, in_imm, in_rn, in_rm, in_rd, in_alu_src, in_alu_op,
               in_opcode, in_reg_write, in_mem_read, in_mem_write, in_branch, stall_in, flush,
               exm_reg_write, exm_rd, exm_result, mwb_reg_write, mwb_rd, mwb_result,
        output hazard_stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch,
               ex_rd, alu_a, alu_b, alu_ctrl, store_data, illegal
    );

endinterface

// File: rtl/id_ex_stage_alu_control.sv
// Combinational ALUOp/opcode -> 4-bit ALU Ctrl decode with an illegal-op flag.
module id_ex_stage_alu_control
    import id_ex_stage_pkg::*;
(
    input  logic        i_valid,
    input  logic [1:0]  i_alu_op,
    input  logic [10:0] i_opcode,
    output logic [3:0]  o_ctrl,
    output logic        o_illegal
);

    logic w_bad;

    always_comb begin
        o_ctrl = ALU_ADD;
        w_bad  = 1'b0;
        case (i_alu_op)
            ALUOP_ADD:   o_ctrl = ALU_ADD;
            ALUOP_PASSB: o_ctrl = ALU_PASSB;
            ALUOP_RTYPE: begin
                case (i_opcode)
                    OPC_ADD: o_ctrl = ALU_ADD;
                    OPC_SUB: o_ctrl = ALU_SUB;
                    OPC_AND: o_ctrl = ALU_AND;
                    OPC_ORR: o_ctrl = ALU_ORR;
                    default: w_bad  = 1'b1;
                endcase
            end
            default:     w_bad = 1'b1;
        endcase
    end

    assign o_illegal = i_valid & w_bad;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the 64-bit ALU: captures decode, resolves
// EX/MEM and MEM/WB forwarding into the operands, and bubbles on load-use.
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst,
    id_ex_stage_if.slave  s_bus
);

    ex_ctrl_t      r_ctrl;
    ex_data_t      r_data;
    ex_ctrl_t      w_cap_ctrl;
    logic [3:0]    w_dec_ctrl;
    logic          w_dec_illegal;
    logic          w_hazard;
    logic [N-1:0]  w_fwd_rn;
    logic [N-1:0]  w_fwd_rm;

    id_ex_stage_alu_control u_alu_control (
        .i_valid   (s_bus.in_valid),
        .i_alu_op  (s_bus.in_alu_op),
        .i_opcode  (s_bus.in_opcode),
        .o_ctrl    (w_dec_ctrl),
        .o_illegal (w_dec_illegal)
    );

    // Upstream hold is suppressed when this edge will not capture anyway.
    assign w_hazard = r_ctrl.valid & r_ctrl.mem_read & (r_data.rd != ZR) & s_bus.in_valid
                    & ((r_data.rd == s_bus.in_rn) | (r_data.rd == s_bus.in_rm))
                    & ~s_bus.stall_in & ~s_bus.flush;

    always_comb begin
        w_cap_ctrl           = '0;
        w_cap_ctrl.valid     = s_bus.in_valid;
        w_cap_ctrl.reg_write = s_bus.in_valid & s_bus.in_reg_write;
        w_cap_ctrl.mem_read  = s_bus.in_valid & s_bus.in_mem_read;
        w_cap_ctrl.mem_write = s_bus.in_valid & s_bus.in_mem_write;
        w_cap_ctrl.branch    = s_bus.in_valid & s_bus.in_branch;
        w_cap_ctrl.illegal   = w_dec_illegal;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ctrl <= '0;
            r_data <= '0;
        end else if (s_bus.flush) begin
            r_ctrl <= '0;
        end else if (!s_bus.stall_in) begin
            r_ctrl         <= w_hazard ? '0 : w_cap_ctrl;
            r_data.rd1     <= s_bus.in_rd1;
            r_data.rd2     <= s_bus.in_rd2;
            r_data.imm     <= s_bus.in_imm;
            r_data.rn      <= s_bus.in_rn;
            r_data.rm      <= s_bus.in_rm;
            r_data.rd      <= s_bus.in_rd;
            r_data.alu_src <= s_bus.in_alu_src;
            r_data.ctrl    <= w_dec_ctrl;
        end
    end

    // EX/MEM is the younger result, so it is checked first.
    always_comb begin
        w_fwd_rn = r_data.rd1;
        if (src_hit(s_bus.exm_reg_write, s_bus.exm_rd, r_data.rn))
            w_fwd_rn = s_bus.exm_result;
        else if (src_hit(s_bus.mwb_reg_write, s_bus.mwb_rd, r_data.rn))
            w_fwd_rn = s_bus.mwb_result;

        w_fwd_rm = r_data.rd2;
        if (src_hit(s_bus.exm_reg_write, s_bus.exm_rd, r_data.rm))
            w_fwd_rm = s_bus.exm_result;
        else if (src_hit(s_bus.mwb_reg_write, s_bus.mwb_rd, r_data.rm))
            w_fwd_rm = s_bus.mwb_result;
    end

    assign s_bus.hazard_stall = w_hazard;
    assign s_bus.ex_valid     = r_ctrl.valid;
    assign s_bus.ex_reg_write = r_ctrl.reg_write;
    assign s_bus.ex_mem_read  = r_ctrl.mem_read;
    assign s_bus.ex_mem_write = r_ctrl.mem_write;
    assign s_bus.ex_branch    = r_ctrl.branch;
    assign s_bus.illegal      = r_ctrl.illegal;
    assign s_bus.ex_rd        = r_data.rd;
    assign s_bus.alu_ctrl     = r_data.ctrl;
    assign s_bus.alu_a        = w_fwd_rn;
    assign s_bus.store_data   = w_fwd_rm;
    assign s_bus.alu_b        = r_data.alu_src ? r_data.imm : w_fwd_rm;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus pushes expected outputs from a
// behavioural model, a negedge monitor pops and compares.
module tb_id_ex_stage;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_ex_stage_if s_bus();

    id_ex_stage dut (
        .i_clk (clk),
        .i_rst (rst),
        .s_bus (s_bus.slave)
    );

    typedef struct {
        bit rst, valid;
        logic [63:0] rd1, rd2, imm;
        logic [4:0] rn, rm, rd;
        bit alu_src;
        logic [1:0] alu_op;
        logic [10:0] opcode;
        bit rw, mr, mw, br, stall, flush;
        bit exm_we; logic [4:0] exm_rd; logic [63:0] exm_res;
        bit mwb_we; logic [4:0] mwb_rd; logic [63:0] mwb_res;
    } stim_t;

    // Instruction currently sitting in EX, as the model sees it.
    typedef struct {
        bit known, valid, rw, mr, mw, br, ill;
        logic [4:0] rd, rn, rm;
        logic [63:0] rd1, rd2, imm;
        bit alu_src;
        logic [3:0] ctrl;
    } mstate_t;

    typedef struct {
        bit known, hz, valid, rw, mr, mw, br, ill;
        logic [4:0] rd;
        logic [63:0] a, b, sd;
        logic [3:0] ctrl;
    } exp_t;

    exp_t q[$];
    mstate_t S;
    logic [3:0] rtab [logic [10:0]];
    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("hazard_stall", 64'(s_bus.hazard_stall), 64'(e.hz));
            chk("ex_valid",     64'(s_bus.ex_valid),     64'(e.valid));
            chk("ex_reg_write", 64'(s_bus.ex_reg_write), 64'(e.rw));
            chk("ex_mem_read",  64'(s_bus.ex_mem_read),  64'(e.mr));
            chk("ex_mem_write", 64'(s_bus.ex_mem_write), 64'(e.mw));
            chk("ex_branch",    64'(s_bus.ex_branch),    64'(e.br));
            chk("illegal",      64'(s_bus.illegal),      64'(e.ill));
            if (e.known) begin
                chk("ex_rd",      64'(s_bus.ex_rd),    64'(e.rd));
                chk("alu_ctrl",   64'(s_bus.alu_ctrl), 64'(e.ctrl));
                chk("alu_a",      s_bus.alu_a,         e.a);
                chk("alu_b",      s_bus.alu_b,         e.b);
                chk("store_data", s_bus.store_data,    e.sd);
            end
        end
    end

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    function automatic stim_t rtype(input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm,
                                    input logic [63:0] v1, input logic [63:0] v2, input logic [10:0] opc);
        stim_t s;
        s = idle();
        s.valid = 1; s.rd = rd; s.rn = rn; s.rm = rm; s.rd1 = v1; s.rd2 = v2;
        s.alu_op = 2'b10; s.opcode = opc; s.rw = 1;
        return s;
    endfunction

    // Architectural register value seen by an EX source after forwarding.
    function automatic logic [63:0] fwd(input stim_t s, input logic [4:0] idx, input logic [63:0] regval);
        if (idx == 5'd31) return regval;
        if (s.exm_we && s.exm_rd == idx) return s.exm_res;
        if (s.mwb_we && s.mwb_rd == idx) return s.mwb_res;
        return regval;
    endfunction

    task automatic drive(input stim_t s);
        rst                 = s.rst;
        s_bus.in_valid      = s.valid;
        s_bus.in_rd1        = s.rd1;
        s_bus.in_rd2        = s.rd2;
        s_bus.in_imm        = s.imm;
        s_bus.in_rn         = s.rn;
        s_bus.in_rm         = s.rm;
        s_bus.in_rd         = s.rd;
        s_bus.in_alu_src    = s.alu_src;
        s_bus.in_alu_op     = s.alu_op;
        s_bus.in_opcode     = s.opcode;
        s_bus.in_reg_write  = s.rw;
        s_bus.in_mem_read   = s.mr;
        s_bus.in_mem_write  = s.mw;
        s_bus.in_branch     = s.br;
        s_bus.stall_in      = s.stall;
        s_bus.flush         = s.flush;
        s_bus.exm_reg_write = s.exm_we;
        s_bus.exm_rd        = s.exm_rd;
        s_bus.exm_result    = s.exm_res;
        s_bus.mwb_reg_write = s.mwb_we;
        s_bus.mwb_rd        = s.mwb_rd;
        s_bus.mwb_result    = s.mwb_res;
    endtask

    function automatic mstate_t zero_state();
        mstate_t z;
        z = '{default: 0};
        z.known = 1;
        return z;
    endfunction

    task automatic step(input stim_t s);
        exp_t e;
        mstate_t n;
        bit hz, bad_op;
        logic [3:0] c;
        drive(s);
        hz = S.valid && S.mr && S.rd != 5'd31 && s.valid && (S.rd == s.rn || S.rd == s.rm)
             && !s.stall && !s.flush;
        e.known = S.known; e.hz = hz; e.valid = S.valid; e.rw = S.rw; e.mr = S.mr;
        e.mw = S.mw; e.br = S.br; e.ill = S.ill; e.rd = S.rd; e.ctrl = S.ctrl;
        e.a  = fwd(s, S.rn, S.rd1);
        e.sd = fwd(s, S.rm, S.rd2);
        e.b  = S.alu_src ? S.imm : e.sd;
        q.push_back(e);

        bad_op = 0;
        if (s.alu_op == 2'b00) c = 4'b0010;
        else if (s.alu_op == 2'b01) c = 4'b0111;
        else if (s.alu_op == 2'b10 && rtab.exists(s.opcode)) c = rtab[s.opcode];
        else begin c = 4'b0010; bad_op = 1; end

        n = S;
        if (s.rst) n = zero_state();
        else if (s.flush || (!s.stall && hz)) begin
            n.known = 0; n.valid = 0; n.rw = 0; n.mr = 0; n.mw = 0; n.br = 0; n.ill = 0;
        end else if (!s.stall) begin
            n.known = 1; n.valid = s.valid;
            n.rw = s.valid & s.rw; n.mr = s.valid & s.mr; n.mw = s.valid & s.mw; n.br = s.valid & s.br;
            n.ill = s.valid & bad_op;
            n.rd = s.rd; n.rn = s.rn; n.rm = s.rm; n.rd1 = s.rd1; n.rd2 = s.rd2; n.imm = s.imm;
            n.alu_src = s.alu_src; n.ctrl = c;
        end
        @(posedge clk);
        #1;
        S = n;
    endtask

    function automatic logic [4:0] ridx();
        return ($urandom_range(0, 8) == 8) ? 5'd31 : 5'($urandom_range(0, 7));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s, f, l, u;
        logic [10:0] opcs [4];
        rtab[11'b10001011000] = 4'b0010;
        rtab[11'b11001011000] = 4'b0110;
        rtab[11'b10001010000] = 4'b0000;
        rtab[11'b10101010000] = 4'b0001;
        opcs[0] = 11'b10001011000; opcs[1] = 11'b11001011000;
        opcs[2] = 11'b10001010000; opcs[3] = 11'b10101010000;

        s = idle(); s.rst = 1;
        drive(s);
        repeat (2) @(posedge clk);
        #1;
        S = zero_state();

        // ADD x3,x1,x2
        step(rtype(3, 1, 2, 64'd5, 64'd7, 11'b10001011000));
        step(idle());

        // EX/MEM beats MEM/WB, then MEM/WB alone, with the stage held
        step(rtype(3, 1, 2, 64'd5, 64'd7, 11'b10001011000));
        f = idle(); f.stall = 1;
        f.exm_we = 1; f.exm_rd = 1; f.exm_res = 64'd99;
        f.mwb_we = 1; f.mwb_rd = 1; f.mwb_res = 64'd44;
        step(f);
        f.exm_we = 0;
        step(f);

        // Zero register is never forwarded
        step(rtype(3, 31, 2, 64'd0, 64'd7, 11'b10001011000));
        f = idle(); f.exm_we = 1; f.exm_rd = 31; f.exm_res = 64'd99;
        step(f);

        // Load-use: LDUR x4 then a consumer of x4, held upstream for one cycle
        l = idle(); l.valid = 1; l.mr = 1; l.rw = 1; l.rd = 4; l.rn = 2; l.alu_src = 1; l.imm = 64'd8;
        step(l);
        u = rtype(5, 4, 6, 64'd11, 64'd22, 11'b11001011000);
        step(u);
        step(u);
        step(idle());

        // Stall two cycles, then flush together with stall, then illegal op
        step(rtype(7, 1, 2, 64'd70, 64'd80, 11'b10101010000));
        f = rtype(9, 3, 4, 64'd123, 64'd456, 11'b10001010000); f.stall = 1;
        step(f);
        step(f);
        f.flush = 1;
        step(f);
        step(idle());
        s = rtype(8, 1, 2, 64'd1, 64'd2, 11'b10001011000); s.alu_op = 2'b11;
        step(s);
        step(idle());

        // Reset mid-stream
        step(rtype(3, 1, 2, 64'd5, 64'd7, 11'b10001011000));
        s = rtype(3, 1, 2, 64'd5, 64'd7, 11'b10001011000); s.rst = 1;
        step(s);
        step(idle());

        for (int i = 0; i < 800; i++) begin
            s = idle();
            s.rst     = ($urandom_range(0, 99) == 0);
            s.valid   = ($urandom_range(0, 9) < 8);
            s.rd1     = {$urandom, $urandom};
            s.rd2     = {$urandom, $urandom};
            s.imm     = {$urandom, $urandom};
            s.rn      = ridx(); s.rm = ridx(); s.rd = ridx();
            s.alu_src = $urandom_range(0, 1);
            s.alu_op  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) s.alu_op = 2'b10;
            s.opcode  = ($urandom_range(0, 9) == 0) ? 11'($urandom) : opcs[$urandom_range(0, 3)];
            s.rw      = $urandom_range(0, 1);
            s.mr      = ($urandom_range(0, 9) < 3);
            s.mw      = $urandom_range(0, 1);
            s.br      = $urandom_range(0, 1);
            s.stall   = ($urandom_range(0, 9) == 0);
            s.flush   = ($urandom_range(0, 11) == 0);
            s.exm_we  = $urandom_range(0, 1); s.exm_rd = ridx(); s.exm_res = {$urandom, $urandom};
            s.mwb_we  = $urandom_range(0, 1); s.mwb_rd = ridx(); s.mwb_res = {$urandom, $urandom};
            step(s);
        end

        step(idle());
        chk("scoreboard_drain", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
